// File: rtl/rsc.sv
// rsc: 8-state rate-1/2 recursive systematic convolutional encoder (g0=13, g1=15) with 3-step trellis termination
module rsc (
   input  logic clk,
   input  logic rst_N,
   input  logic in,
   input  logic mode,
   output logic x_out,
   output logic z_out,
   output logic valid_out
);
   logic s1, s2, s3;
   logic [1:0] tcnt;
   logic f, w, idle;
   // feedback term, shift-register input (forced to 0 while terminating) and idle detection
   always_comb begin
      f    = s2 ^ s3;
      w    = mode ? 1'b0 : in ^ f;
      idle = mode && tcnt == 2'd3;
   end
   // encoder state, tail counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_N) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         tcnt      <= 2'd0;
         x_out     <= 1'b0;
         z_out     <= 1'b0;
         valid_out <= 1'b0;
      end else if (idle) begin
         x_out     <= 1'b0;
         z_out     <= 1'b0;
         valid_out <= 1'b0;
      end else begin
         x_out     <= mode ? f : in;
         z_out     <= w ^ s1 ^ s3;
         valid_out <= 1'b1;
         s1        <= w;
         s2        <= s1;
         s3        <= s2;
         tcnt      <= mode ? tcnt + 2'd1 : 2'd0;
      end
   end
endmodule

// File: tb/tb_rsc.sv
// tb_rsc: randomized and directed checks of rsc against a polynomial-based reference model
module tb_rsc;
   logic clk = 1'b0, rst_N = 1'b0, in = 1'b0, mode = 1'b0;
   logic x_out, z_out, valid_out;
   bit run = 1'b1;
   int total = 0, bad = 0;
   bit [3:1] d;
   int tc;
   logic [2:0] mexp;
   logic [2:0] blk_a [20];
   logic [2:0] held;

   rsc dut (.clk(clk), .rst_N(rst_N), .in(in), .mode(mode),
            .x_out(x_out), .z_out(z_out), .valid_out(valid_out));

   always begin
      #5;
      if (run) clk = ~clk;
   end

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {x,z,v}=%b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // reference: delay line d[k] holds the D^k term; g0 = 1+D^2+D^3, g1 = 1+D+D^3
   function automatic void model(input bit r, input bit i, input bit m);
      bit fb, u, w;
      if (!r) begin
         d = '0; tc = 0; mexp = 3'b000;
      end else if (m && tc >= 3) begin
         mexp = 3'b000;
      end else begin
         fb = ^(d & 3'b110);
         u = m ? fb : i;
         w = u ^ fb;
         mexp = {u, w ^ (^(d & 3'b101)), 1'b1};
         d = {d[2], d[1], w};
         tc = m ? tc + 1 : 0;
      end
   endfunction

   task automatic step(input bit r, input bit i, input bit m, input string tag);
      rst_N = r; in = i; mode = m;
      @(posedge clk);
      #1;
      model(r, i, m);
      chk(tag, {x_out, z_out, valid_out}, mexp);
   endtask

   function automatic logic [2:0] obs();
      return {x_out, z_out, valid_out};
   endfunction

   task automatic data4(input string tag);
      logic [3:0] bits = 4'b1010;
      logic [7:0] xz = 8'b11_01_10_00;
      for (int k = 0; k < 4; k++) begin
         step(1, bits[3-k], 0, {tag, "_model"});
         chk({tag, "_const"}, obs(), {xz[7-2*k], xz[6-2*k], 1'b1});
      end
   endtask

   initial begin
      // reset with toggling inputs
      step(0, 1, 1, "rst0");
      chk("rst0_const", obs(), 3'b000);
      step(0, 0, 1, "rst1");
      chk("rst1_const", obs(), 3'b000);
      data4("enc");
      // state now 100: terminate for 5 cycles
      begin
         logic [5:0] tl = 6'b01_10_11;
         for (int k = 0; k < 3; k++) begin
            step(1, $urandom_range(0, 1), 1, "tail_model");
            chk("tail_const", obs(), {tl[5-2*k], tl[4-2*k], 1'b1});
         end
         for (int k = 0; k < 2; k++) begin
            step(1, $urandom_range(0, 1), 1, "idle_model");
            chk("idle_const", obs(), 3'b000);
         end
      end
      // back-to-back blocks reproduce each other
      for (int k = 0; k < 20; k++) begin
         step(1, k[0], 0, "blkA");
         blk_a[k] = obs();
      end
      for (int k = 0; k < 5; k++) step(1, 0, 1, "blk_tail");
      for (int k = 0; k < 20; k++) begin
         step(1, k[0], 0, "blkB");
         chk("blk_repeat", obs(), blk_a[k]);
      end
      for (int k = 0; k < 5; k++) step(1, 0, 1, "blk_tail2");
      // aborted tail from state 100, then a fresh full tail
      step(1, 1, 0, "ab_setup");
      step(1, 0, 1, "ab_tail");
      chk("ab_tail_const", obs(), 3'b011);
      step(1, 0, 0, "ab_resume");
      chk("ab_resume_const", obs(), 3'b011);
      for (int k = 0; k < 4; k++) step(1, 0, 1, "ab_fresh_tail");
      chk("ab_fresh_idle", obs(), 3'b000);
      // reset during tail step 2
      step(1, 1, 0, "mr_setup");
      step(1, 0, 1, "mr_tail1");
      step(0, 0, 1, "mr_rst");
      chk("mr_rst_const", obs(), 3'b000);
      data4("mr_enc");
      // gated clock: registers hold with no edge
      held = obs();
      run = 1'b0;
      in = ~in; mode = 1'b1; rst_N = 1'b0;
      #100;
      chk("gated_hold", obs(), held);
      run = 1'b1;
      // randomized traffic
      for (int k = 0; k < 600; k++)
         step($urandom_range(0, 99) >= 3, $urandom_range(0, 1),
              $urandom_range(0, 99) < 30, "rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
